// File: rtl/nn_pkg.sv
// Shared definitions for the neuron datapath: activation codes, FSM states, saturation.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// sat() works on a fixed 64-bit signed carrier; every intermediate in the
// neuron (accumulator, shifted accumulator plus bias) must fit below 64 bits.
package nn_pkg;

  // Activation encodings, selected from the string parameter ACT.
  localparam int ACT_RELU   = 0;
  localparam int ACT_LINEAR = 1;

  // Neuron control FSM.
  typedef enum logic [1:0] {
    ACCUM  = 2'd0,
    DRAIN  = 2'd1,
    FINISH = 2'd2,
    HOLD   = 2'd3
  } nl_state_t;

  // Wide signed carrier used for all saturating arithmetic.
  localparam int SAT_W = 64;
  typedef logic signed [SAT_W-1:0] wide_t;

  // Clamp x to the signed range of a w-bit value: [-2^(w-1), 2^(w-1)-1].
  function automatic wide_t sat(input wide_t x, input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
    lo = -(wide_t'(1) <<< (w - 1));
    if (x > hi) begin
      return hi;
    end else if (x < lo) begin
      return lo;
    end
    return x;
  endfunction

endpackage

// File: rtl/lane_weight_bank.sv
// One lane's weight store: single write port, single registered read port.
// Latency: 1 cycle from raddr to rdata.
// Backpressure: none; a write and a read to the same address in one cycle reads the old word.
//
// Ports: clk; we/waddr/wdata write port; raddr/rdata synchronous read port.
// Contents are not reset; weights survive rst by design.
module lane_weight_bank
  import nn_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 196,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read-before-write: the read samples the array before the write lands.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/neuron_lanes.sv
// Fully-connected neuron: LANES-wide multiply-accumulate over banked weights, bias, activation.
// Latency: result valid 4 cycles after the last beat is accepted; BEATS+4 cycles per vector minimum.
// Backpressure: in_ready only in ACCUM; result held in HOLD until out_ready, input stalled meanwhile.
//
// Ports:
//   clk, rst (synchronous, active-high)
//   in_data/in_valid/in_ready   : LANES samples per beat, lane i at [i*DATA_W +: DATA_W]
//   w_valid/w_data, b_valid/b_data, cfg_neuron : weight and bias load, gated by NEURON_ID
//   out_data/out_valid/out_ready : activated result
// Build option: define NEURON_ROUND_EN to round half-up instead of truncating toward -inf.
module neuron_lanes
  import nn_pkg::*;
#(
  parameter int    NEURON_ID  = 0,
  parameter int    NUM_WEIGHT = 784,
  parameter int    DATA_W     = 16,
  parameter int    FRAC_W     = 8,
  parameter int    LANES      = 4,
  parameter int    ACC_W      = 2*DATA_W + $clog2(NUM_WEIGHT),
  parameter string ACT        = "RELU"
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [LANES*DATA_W-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    w_valid,
  input  logic [DATA_W-1:0]       w_data,
  input  logic                    b_valid,
  input  logic [DATA_W-1:0]       b_data,
  input  logic [31:0]             cfg_neuron,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_valid,
  input  logic                    out_ready
);

  localparam int BEATS   = NUM_WEIGHT / LANES;
  localparam int AW      = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int LW      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int PW      = 2 * DATA_W;
  localparam int ACT_SEL = (ACT == "LINEAR") ? ACT_LINEAR : ACT_RELU;

  // ---------------------------------------------------------------- config
  logic w_load;
  logic b_load;
  assign w_load = w_valid && (cfg_neuron == 32'(NEURON_ID));
  assign b_load = b_valid && (cfg_neuron == 32'(NEURON_ID));

  // Weight k lands in lane k%LANES at address k/LANES; the pointer walks
  // lane-first and wraps after NUM_WEIGHT writes.
  logic [LW-1:0] w_lane;
  logic [AW-1:0] w_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_lane <= '0;
      w_addr <= '0;
    end else if (w_load) begin
      if (w_lane == LW'(LANES - 1)) begin
        w_lane <= '0;
        w_addr <= (w_addr == AW'(BEATS - 1)) ? '0 : w_addr + AW'(1);
      end else begin
        w_lane <= w_lane + LW'(1);
      end
    end
  end

  // Bias is kept across rst, like the weights.
  logic [DATA_W-1:0] bias_q;

  always_ff @(posedge clk) begin
    if (b_load) begin
      bias_q <= b_data;
    end
  end

  // ---------------------------------------------------------------- banks
  nl_state_t         state;
  logic [AW-1:0]     beat_cnt;
  logic              beat_acc;
  logic [DATA_W-1:0] rd_w [LANES];

  assign beat_acc = in_valid && in_ready;

  // Read address is the beat counter, so the word for the beat accepted this
  // cycle shows up next cycle alongside the registered input.
  for (genvar i = 0; i < LANES; i++) begin : g_bank
    lane_weight_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (BEATS),
      .AW     (AW)
    ) u_bank (
      .clk   (clk),
      .we    (w_load && (w_lane == LW'(i))),
      .waddr (w_addr),
      .wdata (w_data),
      .raddr (beat_cnt),
      .rdata (rd_w[i])
    );
  end

  // ---------------------------------------------------------------- pipeline
  logic [LANES*DATA_W-1:0] in_q;
  logic                    s1_vld;
  logic                    s2_vld;
  logic signed [PW-1:0]    prod_c [LANES];
  logic signed [PW-1:0]    prod_q [LANES];

  // S1: input register (bank read happens in parallel).
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      in_q <= in_data;
    end
  end

  // S2: per-lane signed products, full 2*DATA_W precision.
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      prod_c[i] = PW'($signed(in_q[i*DATA_W +: DATA_W])) * PW'($signed(rd_w[i]));
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      prod_q[i] <= prod_c[i];
    end
  end

  // S3: sum of lane products added to a saturating accumulator.
  logic signed [ACC_W-1:0] acc;
  wide_t                   sum_c;
  wide_t                   acc_ext;
  wide_t                   acc_nxt;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_c = sum_c + SAT_W'(prod_q[i]);
    end
    acc_ext = SAT_W'(acc);
    acc_nxt = sat(acc_ext + sum_c, ACC_W);
  end

  // ---------------------------------------------------------------- result
  logic [DATA_W-1:0] bias_eff;
  wide_t             bias_ext;
  wide_t             acc_rnd;
  wide_t             r_c;
  logic [DATA_W-1:0] act_c;

`ifdef NEURON_ROUND_EN
  localparam wide_t HALF = wide_t'(1) <<< (FRAC_W - 1);
`endif

  always_comb begin
    // A bias write landing in the FINISH cycle is forwarded into this result.
    bias_eff = b_load ? b_data : bias_q;
    bias_ext = SAT_W'($signed(bias_eff));
`ifdef NEURON_ROUND_EN
    acc_rnd = sat(acc_ext + HALF, ACC_W);
`else
    acc_rnd = acc_ext;
`endif
    r_c = sat((acc_rnd >>> FRAC_W) + bias_ext, DATA_W);
    if ((ACT_SEL == ACT_LINEAR) || !r_c[SAT_W-1]) begin
      act_c = r_c[DATA_W-1:0];
    end else begin
      act_c = '0;
    end
  end

  // ---------------------------------------------------------------- control
  // Two DRAIN cycles let the last beat pass S2 and S3 before FINISH reads acc.
  logic drain_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACCUM;
      beat_cnt  <= '0;
      drain_cnt <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      acc       <= '0;
    end else begin
      // Stage valids follow the data regardless of input gaps.
      s1_vld <= beat_acc;
      s2_vld <= s1_vld;

      if (state == FINISH) begin
        acc <= '0;
      end else if (s2_vld) begin
        acc <= acc_nxt[ACC_W-1:0];
      end

      case (state)
        ACCUM: begin
          if (beat_acc) begin
            if (beat_cnt == AW'(BEATS - 1)) begin
              beat_cnt  <= '0;
              drain_cnt <= 1'b0;
              in_ready  <= 1'b0;
              state     <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt + AW'(1);
            end
          end
        end
        DRAIN: begin
          if (drain_cnt) begin
            state <= FINISH;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        FINISH: begin
          out_data  <= act_c;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: doc/neuron_lanes.md
# neuron_lanes

Parametrised successor to the single-lane neuron. Computes one fully-connected neuron output from a NUM_WEIGHT-element input vector. It processes LANES samples per beat against banked weight memory, adds a runtime-loadable bias, and applies a selectable activation. Ready/valid handshakes on both sides let it sit between a layer input streamer and the layer output collector.

## Interface
Parameters:
- NEURON_ID, 0: this neuron's index; it matches against cfg_neuron.
- NUM_WEIGHT, 784: vector length. Must be a multiple of LANES.
- DATA_W, 16: width of the signed fixed-point input, weight, bias and output.
- FRAC_W, 8: number of fraction bits in DATA_W.
- LANES, 4: samples per beat; 1..16.
- ACC_W, 2*DATA_W+$clog2(NUM_WEIGHT): accumulator width.
- ACT, "RELU": activation select, "RELU" or "LINEAR".

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_data  in  LANES*DATA_W  input samples; lane i is in bits [i*DATA_W +: DATA_W]
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid&in_ready
- w_valid  in  1  weight write strobe
- w_data  in  DATA_W  weight value
- b_valid  in  1  bias write strobe
- b_data  in  DATA_W  bias value
- cfg_neuron  in  32  target neuron for weight/bias writes
- out_data  out  DATA_W  activated result
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid&out_ready

## Operation
- BEATS = NUM_WEIGHT/LANES.
- Weight memory has LANES banks, each BEATS deep.
- Weight load:
  - Load is enabled by w_valid & (cfg_neuron==NEURON_ID).
  - The k-th weight written goes to bank k%LANES, address k/LANES.
  - The write pointer wraps to 0 after NUM_WEIGHT writes.
- Bias is loaded on b_valid & (cfg_neuron==NEURON_ID).
- Weights and bias are not cleared by rst. The weight write pointer resets to 0.
- FSM states: ACCUM, DRAIN, FINISH, HOLD.
  - ACCUM: in_ready=1. Each accepted beat increments the beat counter.
    - The accepted beat's index is the bank read address. All banks read synchronously.
    - After the final beat (index BEATS-1) is accepted, the FSM goes to DRAIN and the counter returns to 0.
  - DRAIN: in_ready=0. Waits 2 cycles while the pipeline empties.
  - FINISH: in_ready=0. One cycle.
    - Computes r = sat_DATA_W((acc >>> FRAC_W) + bias).
    - Applies the activation and registers the result into out_data.
    - Sets out_valid, clears acc, and goes to HOLD.
  - HOLD: in_ready=0. out_data and out_valid are held stable until out_ready. Then out_valid=0 and the FSM goes to ACCUM.
- Pipeline:
  - S1: bank read; input registered.
  - S2: LANES signed DATA_W×DATA_W products, 2*DATA_W wide.
  - S3: adder tree sum, added to acc.
- Arithmetic:
  - acc is signed ACC_W and saturates at ±(2^(ACC_W-1)) rather than wrapping.
  - The shift by FRAC_W is arithmetic.
  - The final result clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Activation:
  - RELU: out = r<0 ? 0 : r.
  - LINEAR: out = r.
- Boundary conditions:
  - A weight write to the address being read in the same cycle returns the old value.
  - A bias write at or before the FINISH cycle is used for that result.
  - A gap in in_valid stalls only the beat counter; the pipeline advances and carries per-stage valid bits.
  - rst mid-vector clears acc, the beat counter, stage valids and out_valid, and the FSM returns to ACCUM.

## Timing
- Reset values: out_valid=0, out_data=0, in_ready=1, FSM=ACCUM, acc=0.
- Throughput: 1 beat/cycle in ACCUM.
- The final beat is accepted in cycle T. Then out_valid=1 in cycle T+4: DRAIN at T+1 and T+2, FINISH at T+3, and the registered output appears at T+4.
- With out_ready=1 at T+4, in_ready=1 at T+5.
- Minimum period per vector: BEATS+4 cycles.

## Configuration
- NEURON_ROUND_EN:
  - Defined: FINISH adds 2^(FRAC_W-1) to acc, with saturation, before the shift. This rounds half-up.
  - Undefined: the result is truncated toward −∞ by the arithmetic shift.

## Structure
- The shared package nn_pkg holds:
  - the ACT encoding constants;
  - the FSM state typedef (ACCUM/DRAIN/FINISH/HOLD);
  - the sat() helper function.
- Sub-module lane_weight_bank:
  - single-write, single synchronous read RAM, DATA_W×BEATS;
  - one instance per lane, instantiated in a generate loop.

## Test plan
All scenarios use DATA_W=16, FRAC_W=8, LANES=4, NUM_WEIGHT=8 unless noted.
- All weights 0x0100, bias 0, inputs all 0x0100 → out_data=0x0800 four cycles after the 2nd beat.
- Inputs all 0xFF00:
  - RELU → 0x0000.
  - LINEAR → 0xF800.
- Inputs and weights all 0x7FFF, bias 0x7FFF → out_data clamps to 0x7FFF. Negating the inputs gives 0x8000 in LINEAR mode.
- Rounding: weight[0]=0x0001, input lane0=0x0080, all else 0 → 0x0000 without NEURON_ROUND_EN, 0x0001 with it.
- Backpressure: hold out_ready=0 for 10 cycles → out_valid and out_data stable, in_ready=0 throughout. On release, the next vector is accepted the following cycle.
- Assert rst after beat 1 of a vector, then send a full vector → the result is correct, with no residue from the aborted vector, and weights and bias are preserved.
